// File: rtl/biss_c_master.sv
// biss_c_master: BiSS-C master for one stepper slot.
// Drives the MA clock, frames SLO into position/nE/nW/CRC6, and publishes a
// CRC-checked position word. Every frame is started by a request and guarded
// by ACK/START/RECOVER timeouts.
//
// Ports
//   clk          system clock
//   resetn       async active-low reset
//   enable       slot is in BiSS mode; low aborts the frame and parks MA high
//   start        1-cycle frame request, ignored while busy
//   slo_in       encoder data line, asynchronous to clk
//   ma_out       encoder clock line
//   busy         frame in progress (state other than IDLE)
//   frame_valid  1-cycle pulse, new CRC-good frame latched
//   position     last CRC-good position
//   err_n        last CRC-good nE bit
//   warn_n       last CRC-good nW bit
//   crc_err      1-cycle pulse, frame received with CRC mismatch
//   timeout_err  1-cycle pulse, ACK/START/RECOVER timeout
//
// state   | meaning
// IDLE    | MA parked high, waiting for start with SLO high
// ACK     | clocking MA, waiting for SLO low (acknowledge)
// START   | waiting for SLO high (start bit)
// CDS     | one control bit, discarded
// DATA    | position, nE, nW shifted in and fed to CRC6
// CRC     | six inverted CRC bits captured
// DONE    | compare CRC, publish or flag the frame
// RECOVER | MA high, waiting for the slave to release SLO
module biss_c_master #(
  parameter int CLK_DIV     = 30,
  parameter int POS_BITS    = 26,
  parameter int ACK_MAX     = 16,
  parameter int TIMEOUT_CYC = 4000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                start,
  input  logic                slo_in,
  output logic                ma_out,
  output logic                busy,
  output logic                frame_valid,
  output logic [POS_BITS-1:0] position,
  output logic                err_n,
  output logic                warn_n,
  output logic                crc_err,
  output logic                timeout_err
);

  localparam int FW = POS_BITS + 2;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = $clog2(TIMEOUT_CYC);
  localparam int BW = 8;
  localparam logic [DW-1:0] DIV_LOAD   = DW'(CLK_DIV - 1);
  localparam logic [RW-1:0] REC_LOAD   = RW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] REC_SETTLE = RW'(TIMEOUT_CYC - 3);
  localparam logic [BW-1:0] ACK_LAST   = BW'(ACK_MAX - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(FW - 1);
  localparam logic [BW-1:0] CRC_LAST   = BW'(5);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_START, S_CDS, S_DATA, S_CRC, S_DONE, S_RECOVER
  } state_t;

  state_t          state, state_nx;
  logic            slo_meta, slo_sync;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [RW-1:0]   rec_cnt;
  logic [FW-1:0]   data_sr;
  logic [5:0]      rx_crc, crc, crc_step;
  logic            running, tc, rise, slo_ready, crc_fb, crc_ok;
  logic            ma_d, fv_d, ce_d, to_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slo_meta <= 1'b1;
      slo_sync <= 1'b1;
    end else begin
      slo_meta <= slo_in;
      slo_sync <= slo_meta;
    end
  end

  assign running  = (state == S_ACK) || (state == S_START) || (state == S_CDS) ||
                    (state == S_DATA) || (state == S_CRC);
  assign tc       = (div_cnt == '0);
  // Sample point: the clk cycle in which MA is about to go 0->1.
  assign rise     = running && tc && !ma_out;
  // The synchronizer still shows the last CRC bit during the first RECOVER
  // cycles, so the release of SLO is only trusted after it has flushed.
  assign slo_ready = slo_sync && (rec_cnt <= REC_SETTLE);
  assign crc_fb   = slo_sync ^ crc[5];
  assign crc_step = {crc[4:0], 1'b0} ^ (crc_fb ? 6'h03 : 6'h00);
  assign crc_ok   = (crc == ~rx_crc);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start && enable && slo_sync) state_nx = S_ACK;
      S_ACK:     if (rise) begin
                   if (!slo_sync)                  state_nx = S_START;
                   else if (bit_cnt == ACK_LAST)   state_nx = S_RECOVER;
                 end
      S_START:   if (rise) begin
                   if (slo_sync)                   state_nx = S_CDS;
                   else if (bit_cnt == ACK_LAST)   state_nx = S_RECOVER;
                 end
      S_CDS:     if (rise) state_nx = S_DATA;
      S_DATA:    if (rise && (bit_cnt == DATA_LAST)) state_nx = S_CRC;
      S_CRC:     if (rise && (bit_cnt == CRC_LAST))  state_nx = S_DONE;
      S_DONE:    state_nx = S_RECOVER;
      S_RECOVER: if (slo_ready || (rec_cnt == '0)) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (!enable) state_nx = S_IDLE;
  end

  always_comb begin
    ma_d = ma_out;
    if ((state_nx == S_IDLE) || (state_nx == S_DONE) || (state_nx == S_RECOVER))
      ma_d = 1'b1;
    else if (running && tc)
      ma_d = ~ma_out;
    to_d = 1'b0;
    if (enable) begin
      case (state)
        S_ACK:     to_d = rise && slo_sync && (bit_cnt == ACK_LAST);
        S_START:   to_d = rise && !slo_sync && (bit_cnt == ACK_LAST);
        S_RECOVER: to_d = !slo_ready && (rec_cnt == '0);
        default:   to_d = 1'b0;
      endcase
    end
    fv_d = enable && (state == S_DONE) && crc_ok;
    ce_d = enable && (state == S_DONE) && !crc_ok;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ma_out      <= 1'b1;
      div_cnt     <= DIV_LOAD;
      bit_cnt     <= '0;
      rec_cnt     <= REC_LOAD;
      data_sr     <= '0;
      rx_crc      <= '0;
      crc         <= '0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      position    <= '0;
      err_n       <= 1'b1;
      warn_n      <= 1'b1;
    end else begin
      ma_out      <= ma_d;
      frame_valid <= fv_d;
      crc_err     <= ce_d;
      timeout_err <= to_d;
      div_cnt     <= (!running || tc) ? DIV_LOAD : div_cnt - 1'b1;
      rec_cnt     <= (state == S_RECOVER) ? rec_cnt - 1'b1 : REC_LOAD;
      if (state_nx != state) bit_cnt <= '0;
      else if (rise)         bit_cnt <= bit_cnt + 1'b1;
      if (state == S_IDLE) crc <= '0;
      if (rise && (state == S_DATA)) begin
        data_sr <= {data_sr[FW-2:0], slo_sync};
        crc     <= crc_step;
      end
      if (rise && (state == S_CRC)) rx_crc <= {rx_crc[4:0], slo_sync};
      if (fv_d) begin
        position <= data_sr[FW-1:2];
        err_n    <= data_sr[1];
        warn_n   <= data_sr[0];
      end
    end
  end

endmodule

// File: tb/tb_biss_c_master.sv
module tb_biss_c_master;
  localparam int CLK_DIV     = 4;
  localparam int POS_BITS    = 26;
  localparam int ACK_MAX     = 16;
  localparam int TIMEOUT_CYC = 4000;
  localparam int NBITS       = 38;  // no-ack, ack, start, cds, 28 data, 6 crc

  logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, start = 1'b0, slo_in = 1'b1;
  logic ma_out, busy, frame_valid, err_n, warn_n, crc_err, timeout_err;
  logic [POS_BITS-1:0] position;

  int total = 0, bad = 0;

  bit seq [NBITS];
  int idx = 0;
  bit bfm_on = 1'b0, cnt_on = 1'b0;
  int rise_cnt = 0;

  int                  exp_kind [$];  // 0 frame_valid, 1 crc_err, 2 timeout_err
  logic [POS_BITS-1:0] exp_pos  [$];
  bit                  exp_ne   [$];
  bit                  exp_nw   [$];
  logic [POS_BITS-1:0] m_pos = '0;
  bit                  m_en = 1'b1, m_wn = 1'b1;

  int cp_np, cp_k, cp_got;
  logic [POS_BITS-1:0] cp_p;
  bit cp_ne, cp_nw;

  biss_c_master #(
    .CLK_DIV(CLK_DIV), .POS_BITS(POS_BITS), .ACK_MAX(ACK_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start), .slo_in(slo_in),
    .ma_out(ma_out), .busy(busy), .frame_valid(frame_valid), .position(position),
    .err_n(err_n), .warn_n(warn_n), .crc_err(crc_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC6 as the remainder of data(x)*x^6 divided by x^6+x+1.
  function automatic logic [5:0] crc_of(input logic [27:0] d);
    logic [33:0] m;
    m = {d, 6'b0};
    for (int i = 33; i >= 6; i--)
      if (m[i]) m[i -: 7] = m[i -: 7] ^ 7'b1000011;
    return m[5:0];
  endfunction

  // Encoder BFM: next bit after each MA fall, line low after the last rise.
  always @(negedge ma_out) begin
    if (bfm_on && idx < NBITS) begin
      #1;
      slo_in = seq[idx];
      idx = idx + 1;
    end
  end

  always @(posedge ma_out) begin
    if (cnt_on) rise_cnt++;
    if (bfm_on && idx == NBITS) begin
      #1;
      slo_in = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      m_pos = '0; m_en = 1'b1; m_wn = 1'b1;
      exp_kind.delete(); exp_pos.delete(); exp_ne.delete(); exp_nw.delete();
      chk("rst_ma_out", ma_out, 1);
      chk("rst_position", position, 0);
      chk("rst_err_n", err_n, 1);
      chk("rst_busy", busy, 0);
    end else begin
      cp_np = int'(frame_valid) + int'(crc_err) + int'(timeout_err);
      chk("single_pulse", 32'(cp_np <= 1), 1);
      if (cp_np != 0) begin
        if (exp_kind.size() == 0) begin
          chk("unexpected_pulse", {frame_valid, crc_err, timeout_err}, 0);
        end else begin
          cp_k = exp_kind.pop_front();
          cp_p = exp_pos.pop_front();
          cp_ne = exp_ne.pop_front();
          cp_nw = exp_nw.pop_front();
          cp_got = frame_valid ? 0 : (crc_err ? 1 : 2);
          chk("pulse_kind", cp_got, cp_k);
          if (cp_k == 0) begin
            m_pos = cp_p; m_en = cp_ne; m_wn = cp_nw;
          end
        end
      end
      chk("position", position, m_pos);
      chk("err_n", err_n, m_en);
      chk("warn_n", warn_n, m_wn);
      if (!busy) chk("ma_idle_high", ma_out, 1);
    end
  end

  task automatic push_exp(input int kind, input logic [25:0] p, input bit ne, input bit nw);
    exp_kind.push_back(kind); exp_pos.push_back(p); exp_ne.push_back(ne); exp_nw.push_back(nw);
  endtask

  task automatic load_seq(input logic [25:0] p, input bit ne, input bit nw, input logic [5:0] flip);
    logic [27:0] d;
    logic [5:0] tx;
    d = {p, ne, nw};
    tx = ~crc_of(d) ^ flip;
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b0;
    for (int i = 0; i < 28; i++) seq[4+i] = d[27-i];
    for (int i = 0; i < 6; i++)  seq[32+i] = tx[5-i];
    idx = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    chk("busy_before_start", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic start_frame(input logic [25:0] p, input bit ne, input bit nw, input logic [5:0] flip);
    load_seq(p, ne, nw, flip);
    bfm_on = 1'b1;
    do_start();
  endtask

  task automatic run_frame(input logic [25:0] p, input bit ne, input bit nw,
                           input logic [5:0] flip, input int hold, input bit spam);
    bit good;
    good = (flip == 6'd0);
    push_exp(good ? 0 : 1, p, ne, nw);
    if (hold > TIMEOUT_CYC) push_exp(2, '0, 1'b0, 1'b0);
    rise_cnt = 0;
    cnt_on = 1'b1;
    start_frame(p, ne, nw, flip);
    for (int k = 0; k < 400 && idx < NBITS; k++) @(negedge clk);
    chk("bfm_bits_sent", idx, NBITS);
    for (int k = 0; k < 4*CLK_DIV && !ma_out; k++) @(negedge clk);
    chk("last_rise_seen", ma_out, 1);
    cnt_on = 1'b0;
    chk("pulse_not_early", {frame_valid, crc_err}, 0);
    @(negedge clk);
    chk("frame_valid_latency", frame_valid, good);
    chk("crc_err_latency", crc_err, !good);
    for (int k = 0; k < hold; k++) begin
      start = spam && (k % 500 == 100);
      @(negedge clk);
    end
    start = 1'b0;
    if (hold > TIMEOUT_CYC) chk("idle_while_slo_low", busy, 0);
    slo_in = 1'b1;
    bfm_on = 1'b0;
    for (int k = 0; k < TIMEOUT_CYC + 100 && busy; k++) @(negedge clk);
    chk("back_to_idle", busy, 0);
    // one non-ACK sample, then ack + start + cds + 28 data + 6 crc
    chk("ma_rises", rise_cnt, 1 + 1 + 1 + 1 + 28 + 6);
    repeat (4) @(negedge clk);
    chk("events_drained", exp_kind.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ma_out", ma_out, 1);
    chk("reset_pulses", {frame_valid, crc_err, timeout_err}, 0);
    chk("reset_warn_n", warn_n, 1);

    chk("model_crc_1", crc_of(28'h1), 6'h03);
    chk("model_crc_2", crc_of(28'h2), 6'h06);
    chk("model_crc_40", crc_of(28'h40), 6'h05);
    chk("model_crc_0", crc_of(28'h0), 6'h00);

    resetn = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // 1: good frame
    run_frame(26'h155AA55, 1'b1, 1'b1, 6'h00, 10, 1'b0);
    chk("s1_position", position, 26'h155AA55);
    chk("s1_err_n", err_n, 1);
    chk("s1_warn_n", warn_n, 1);

    // 2: CRC bit 0 flipped, same frame and a different payload
    run_frame(26'h155AA55, 1'b1, 1'b1, 6'h01, 10, 1'b0);
    run_frame(26'h2ABCDEF, 1'b0, 1'b1, 6'h01, 10, 1'b0);
    chk("s2_position_kept", position, 26'h155AA55);

    // 3: SLO stuck high
    push_exp(2, '0, 1'b0, 1'b0);
    rise_cnt = 0;
    cnt_on = 1'b1;
    do_start();
    for (int k = 0; k < 40*CLK_DIV + 20 && !timeout_err; k++) @(negedge clk);
    chk("ack_timeout_seen", timeout_err, 1);
    cnt_on = 1'b0;
    chk("ack_samples", rise_cnt, ACK_MAX);
    chk("ack_timeout_ma", ma_out, 1);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    chk("ack_timeout_idle", busy, 0);
    run_frame(26'h2ABCDEF, 1'b0, 1'b1, 6'h00, 10, 1'b0);
    chk("s3_position", position, 26'h2ABCDEF);

    // 4: enable dropped at data bit 10
    start_frame(26'h3FFFFFF, 1'b1, 1'b0, 6'h00);
    for (int k = 0; k < 400 && idx < 15; k++) @(negedge clk);
    chk("abort_reached_bit10", idx, 15);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_ma_out", ma_out, 1);
    chk("abort_busy", busy, 0);
    bfm_on = 1'b0;
    slo_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_position_kept", position, 26'h2ABCDEF);
    enable = 1'b1;
    run_frame(26'h3FFFFFF, 1'b1, 1'b0, 6'h00, 10, 1'b0);

    // 5: SLO held low after frame, starts while busy
    run_frame(26'h0123456, 1'b0, 1'b0, 6'h00, 5000, 1'b1);
    chk("s5_position", position, 26'h0123456);
    chk("s5_err_n", err_n, 0);

    // 6: reset mid-CRC
    start_frame(26'h1000000, 1'b1, 1'b1, 6'h00);
    for (int k = 0; k < 400 && idx < 34; k++) @(negedge clk);
    chk("rst_reached_crc", idx, 34);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_ma_out", ma_out, 1);
    chk("async_rst_position", position, 0);
    chk("async_rst_err_n", err_n, 1);
    chk("async_rst_warn_n", warn_n, 1);
    chk("async_rst_busy", busy, 0);
    bfm_on = 1'b0;
    slo_in = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(26'h1000000, 1'b1, 1'b1, 6'h00, 10, 1'b0);
    chk("s6_position", position, 26'h1000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
